// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU/REM/REMU).
// Holds EX_alu_busy while an operation is in flight; pulses div_done with the result.
`ifndef ALU_DIV
`define ALU_DIV  5'h0C
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'h0D
`endif
`ifndef ALU_REM
`define ALU_REM  5'h0E
`endif
`ifndef ALU_REMU
`define ALU_REMU 5'h0F
`endif

module ex_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [4:0]      ex_alu_func,
    input  logic [XLEN-1:0] ex_opa,
    input  logic [XLEN-1:0] ex_opb,
    output logic            EX_alu_busy,
    output logic            div_done,
    output logic [XLEN-1:0] div_result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, state_nxt;
    logic [XLEN-1:0] r, q, b_mag;
    logic [CNT_W-1:0] cnt;
    logic            qs, rs, want_rem;

    logic            is_div, start, is_signed, rem_sel;
    logic [XLEN-1:0] a_mag_in, b_mag_in, special_res;
    logic            div_zero, overflow, special;
    logic [XLEN:0]   r_shift;
    logic            ge;
    logic [XLEN-1:0] r_next, q_next, fin_res;

    // Operation decode and corner-case detection on the incoming operands
    always_comb begin
        is_div    = (ex_alu_func == `ALU_DIV)  || (ex_alu_func == `ALU_DIVU) ||
                    (ex_alu_func == `ALU_REM)  || (ex_alu_func == `ALU_REMU);
        start     = ex_valid & is_div;
        is_signed = (ex_alu_func == `ALU_DIV) || (ex_alu_func == `ALU_REM);
        rem_sel   = (ex_alu_func == `ALU_REM) || (ex_alu_func == `ALU_REMU);
        a_mag_in  = (is_signed && ex_opa[XLEN-1]) ? -ex_opa : ex_opa;
        b_mag_in  = (is_signed && ex_opb[XLEN-1]) ? -ex_opb : ex_opb;
        div_zero  = (ex_opb == '0);
        overflow  = is_signed && (ex_opa == MIN_VAL) && (ex_opb == '1);
        special   = div_zero | overflow;
        if (rem_sel) special_res = div_zero ? ex_opa : '0;
        else         special_res = div_zero ? '1 : MIN_VAL;
    end

    // One restoring step: shift {R,Q} left, trial-subtract the divisor magnitude
    always_comb begin
        r_shift = {r, q[XLEN-1]};
        ge      = (r_shift >= {1'b0, b_mag});
        r_next  = ge ? XLEN'(r_shift - {1'b0, b_mag}) : r_shift[XLEN-1:0];
        q_next  = {q[XLEN-2:0], ge};
        fin_res = want_rem ? (rs ? -r_next : r_next) : (qs ? -q_next : q_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        EX_alu_busy = 1'b0;
        div_done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    EX_alu_busy = ~rst;
                    state_nxt   = special ? DONE : RUN;
                end
            end
            RUN: begin
                EX_alu_busy = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                div_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r          <= '0;
            q          <= '0;
            b_mag      <= '0;
            cnt        <= '0;
            qs         <= 1'b0;
            rs         <= 1'b0;
            want_rem   <= 1'b0;
            div_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r        <= '0;
                        q        <= a_mag_in;
                        b_mag    <= b_mag_in;
                        cnt      <= CNT_W'(XLEN);
                        qs       <= is_signed & (ex_opa[XLEN-1] ^ ex_opb[XLEN-1]);
                        rs       <= is_signed & ex_opa[XLEN-1];
                        want_rem <= rem_sel;
                        if (special) div_result <= special_res;
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - CNT_W'(1);
                    // The last step's outcome is signed and registered as we enter DONE
                    if (cnt == CNT_W'(1)) div_result <= fin_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
`ifndef ALU_DIV
`define ALU_DIV  5'h0C
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'h0D
`endif
`ifndef ALU_REM
`define ALU_REM  5'h0E
`endif
`ifndef ALU_REMU
`define ALU_REMU 5'h0F
`endif

module tb_ex_div_unit;

    localparam logic [4:0] F_DIV  = `ALU_DIV;
    localparam logic [4:0] F_DIVU = `ALU_DIVU;
    localparam logic [4:0] F_REM  = `ALU_REM;
    localparam logic [4:0] F_REMU = `ALU_REMU;
    localparam logic [4:0] F_ADD  = 5'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_alu_func;
    logic [31:0] ex_opa, ex_opb;
    logic        EX_alu_busy, div_done;
    logic [31:0] div_result;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    ex_div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_func(ex_alu_func),
        .ex_opa(ex_opa), .ex_opb(ex_opb), .EX_alu_busy(EX_alu_busy),
        .div_done(div_done), .div_result(div_result)
    );

    // Reference: RISC-V M-extension semantics via 64-bit signed arithmetic
    function automatic logic [31:0] ref_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, t;
        if (b == 32'd0) return (f == F_DIV || f == F_DIVU) ? 32'hFFFF_FFFF : a;
        if (f == F_DIVU) return a / b;
        if (f == F_REMU) return a % b;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        t  = (f == F_DIV) ? sa / sb : sa % sb;
        return t[31:0];
    endfunction

    function automatic bit is_special(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ||
               ((f == F_DIV || f == F_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one op at posedge+1; returns at posedge+1 after the DONE cycle
    task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] exp_res, got_res;
        int exp_lat, lat;
        bit busy_ok;
        exp_res = ref_op(f, a, b);
        exp_lat = is_special(f, a, b) ? 1 : 33;
        lat = -1;
        busy_ok = 1'b1;
        got_res = 32'hx;
        ex_valid = 1'b1; ex_alu_func = f; ex_opa = a; ex_opb = b;
        for (int k = 0; k < 60 && lat < 0; k++) begin
            @(negedge clk);
            if (div_done) begin
                lat = k;
                got_res = div_result;
                if (EX_alu_busy) busy_ok = 1'b0;
            end else if (!EX_alu_busy) begin
                busy_ok = 1'b0;
            end
            @(posedge clk); #1;
            // Operands are latched at t0; later changes must be ignored
            ex_opa = $urandom;
            ex_opb = $urandom;
        end
        ex_valid = 1'b0;
        last_result = exp_res;
        n_checks++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (busy_ok !== 1'b1) $display("FAIL %s busy: got irregular busy, expected high until done", name);
        else n_pass++;
        n_checks++;
        if (got_res !== exp_res) $display("FAIL %s result: got %h expected %h", name, got_res, exp_res);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({EX_alu_busy, div_done, div_result} !== 34'd0)
            $display("FAIL reset_state: got busy=%b done=%b res=%h expected 0/0/0", EX_alu_busy, div_done, div_result);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({EX_alu_busy, div_done, div_result} !== 34'd0)
            $display("FAIL post_reset_idle: got busy=%b done=%b res=%h expected 0/0/0", EX_alu_busy, div_done, div_result);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(F_DIVU, 32'd100, 32'd7, "divu_100_7");
        run_op(F_REMU, 32'd100, 32'd7, "remu_100_7");
        run_op(F_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(F_REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_op(F_DIV,  32'd7, 32'hFFFF_FFFE, "div_7_m2");
        run_op(F_REM,  32'd7, 32'hFFFF_FFFE, "rem_7_m2");
    endtask

    task automatic test_special();
        run_op(F_DIVU, 32'h1234, 32'd0, "divu_by_zero");
        run_op(F_REM,  32'h1234, 32'd0, "rem_by_zero");
        run_op(F_DIV,  32'hFFFF_FF00, 32'd0, "div_neg_by_zero");
        run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
    endtask

    task automatic test_reset_midop();
        bit saw_done;
        ex_valid = 1'b1; ex_alu_func = F_DIVU; ex_opa = 32'd1000; ex_opb = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; ex_valid = 1'b0;
        #1;
        n_checks++;
        if (EX_alu_busy !== 1'b0) $display("FAIL midop_reset_busy: got %b expected 0", EX_alu_busy);
        else n_pass++;
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (div_done) saw_done = 1'b1;
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (div_done) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) $display("FAIL midop_reset_done: got done pulse, expected none");
        else n_pass++;
        n_checks++;
        if (div_result !== 32'd0) $display("FAIL midop_reset_result: got %h expected 0", div_result);
        else n_pass++;
        @(posedge clk); #1;
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'd3, "divu_after_reset");
    endtask

    task automatic test_back_to_back();
        bit busy_seen, done_seen;
        run_op(F_REMU, 32'd10, 32'd3, "b2b_remu");
        run_op(F_DIV,  32'd9,  32'd3, "b2b_div");
        @(negedge clk);
        n_checks++;
        if (div_done !== 1'b0 || div_result !== last_result)
            $display("FAIL result_hold: got done=%b res=%h expected 0/%h", div_done, div_result, last_result);
        else n_pass++;
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_alu_func = F_ADD; ex_opa = 32'd5; ex_opb = 32'd6;
        busy_seen = 1'b0; done_seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (EX_alu_busy) busy_seen = 1'b1;
            if (div_done) done_seen = 1'b1;
        end
        n_checks++;
        if (busy_seen !== 1'b0 || done_seen !== 1'b0)
            $display("FAIL add_ignored: got busy=%b done=%b expected 0/0", busy_seen, done_seen);
        else n_pass++;
        @(posedge clk); #1;
        run_op(F_REMU, 32'd10, 32'd3, "after_add_remu");
    endtask

    task automatic test_random();
        logic [4:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 3))
                0: f = F_DIV;
                1: f = F_DIVU;
                2: f = F_REM;
                default: f = F_REMU;
            endcase
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            run_op(f, a, b, $sformatf("random_%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_alu_func = F_ADD; ex_opa = '0; ex_opb = '0;
        last_result = '0;
        test_reset();
        test_directed();
        test_special();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_div_unit.md
Name: ex_div_unit

Overview:
- Iterative multi-cycle integer divider in the EX stage. Executes `ALU_DIV, `ALU_DIVU, `ALU_REM and `ALU_REMU.
- Drives the EX_alu_busy signal that the pipeline stall logic uses to freeze all pipeline registers while a divide or remainder operation is in flight.
- Uses radix-2 restoring division on magnitudes. Signs are fixed up at completion, and RISC-V corner cases are handled in a single cycle.

Parameters:
XLEN, 32, operand/result width
CNT_W, 6, iteration counter width, must satisfy 2^CNT_W > XLEN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
ex_valid  in  1  the ID/EX register holds a valid instruction
ex_alu_func  in  5  ALU function code from the ID/EX register
ex_opa  in  XLEN  dividend (rs1 value)
ex_opb  in  XLEN  divisor (rs2 value)
EX_alu_busy  out  1  operation in progress; pipeline must hold
div_done  out  1  one-cycle pulse; div_result is valid
div_result  out  XLEN  quotient or remainder

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high. On reset:
  - state=IDLE
  - EX_alu_busy=0, div_done=0, div_result=0
  - counter=0 and all datapath registers cleared.
- start = ex_valid & (ex_alu_func is one of `ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU).
- Signedness and selection:
  - signed = DIV/REM.
  - want_rem = REM/REMU.
- EX_alu_busy is combinational: (state==IDLE & start) | (state==RUN). It rises in the same cycle the instruction enters EX, so the stall logic freezes the pipeline with zero bubble.
- States:
  - IDLE, with start:
    - Latch |opa| and |opb| (magnitudes only when signed), plus the quotient sign qs = signed & (opa[XLEN-1]^opb[XLEN-1]) and the remainder sign rs = signed & opa[XLEN-1].
    - Latch want_rem. Clear partial remainder R. Load the quotient/shift register Q with |opa|. Set counter=XLEN.
    - If divisor==0 or (signed & opa==min & opb==all-ones): compute the special result directly and go to DONE.
    - Otherwise go to RUN.
  - IDLE, without start: stay.
  - RUN, each cycle:
    - Compute {R,Q} shifted left by 1, giving R'.
    - If R' >= |opb| (unsigned, XLEN+1-bit compare): R = R'-|opb| and Q[0]=1. Else R = R' and Q[0]=0.
    - Decrement counter. When counter reaches 1 in this cycle, go to DONE.
    - RUN lasts exactly XLEN cycles.
  - DONE:
    - div_done=1 and EX_alu_busy=0.
    - div_result is registered: qs ? -Q : Q when quotient is requested, rs ? -R : R when remainder is requested.
    - Unconditionally go to IDLE next cycle. start is ignored in DONE, because the instruction presented is the completing one and the pipeline advances at the end of this cycle.
- Latency (start seen in cycle t0):
  - Normal ops: busy high t0..t32, done and result at t33. Total 34 cycles, 33 stall cycles.
  - Special cases: busy at t0, done at t1.
- Special results:
  - Divide by zero: quotient = all-ones (DIV and DIVU), remainder = opa.
  - Signed overflow (min / -1): quotient = min, remainder = 0.
- Operand hold: operands are latched at t0. Input changes during RUN have no effect.
- Back-to-back operations: a new divide arriving in the cycle after DONE (state IDLE) starts normally. There is no idle gap requirement.
- div_result holds its value until the next DONE or reset. div_done is a single-cycle pulse.
- Reset mid-operation: immediate return to IDLE. EX_alu_busy drops asynchronously and no div_done is issued.
- Non-divide functions: ignored. Busy stays 0 and no state change occurs.

Test Plan:
- DIVU 100/7 at t0 -> EX_alu_busy=1 for t0..t32; at t33 div_done=1, result=14. Repeat with REMU -> result=2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3); REM -> 0xFFFFFFFF(-1). DIV 7/0xFFFFFFFE(-2) -> 0xFFFFFFFD, REM -> 1.
- DIVU 0x1234/0 -> done at t1, result 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; busy exactly one cycle.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at t1; REM same operands -> 0.
- Assert rst at t10 of a DIVU -> busy=0 immediately, no div_done pulse. A following DIVU 0xFFFFFFFF/3 -> 0x55555555 at the normal latency.
- Back-to-back: REMU 10/3 then DIV 9/3 issued in the cycle after DONE -> results 1 then 3, two independent 34-cycle windows. A non-divide ADD presented between them -> busy stays 0.
